// File: rtl/omsp_tsc_reader_if.sv
// Peripheral-bus bundle between the TSC reader (master) and the bus/arbiter side (slave).
interface omsp_tsc_reader_if;
  logic        per_req;
  logic        per_gnt;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  modport master (
    output per_req,
    output per_en,
    output per_we,
    output per_addr,
    output per_din,
    input  per_gnt,
    input  per_dout
  );

  modport slave (
    input  per_req,
    input  per_en,
    input  per_we,
    input  per_addr,
    input  per_din,
    output per_gnt,
    output per_dout
  );
endinterface

// File: rtl/omsp_tsc_reader.sv
// Bus initiator fetching a coherent 64-bit time-stamp from the TSC peripheral.
// Optional macro TSC_READER_DELTA_EN adds tsc_delta (difference to the previous fetch).

module omsp_tsc_reader_chk (
  input logic        mclk,
  input logic        puc_rst,
  input logic        per_req,
  input logic        per_en,
  input logic [1:0]  per_we,
  input logic [13:0] per_addr,
  input logic        tsc_vld,
  input logic        busy
);
  a_en_needs_req: assert property (@(posedge mclk) disable iff (puc_rst) per_en |-> per_req);
  a_idle_bus_quiet: assert property (@(posedge mclk) disable iff (puc_rst)
    !per_en |-> (per_we == 2'b00) && (per_addr == 14'h0000));
  a_vld_needs_busy: assert property (@(posedge mclk) disable iff (puc_rst) tsc_vld |-> busy);
endmodule

module omsp_tsc_reader #(
  parameter logic [14:0] BASE_ADDR = 15'h0100
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                start,
  output logic                busy,
  output logic [63:0]         tsc_val,
  output logic                tsc_vld,
  input  logic                tsc_ack,
  output logic [63:0]         tsc_delta,
  omsp_tsc_reader_if.master   bus
);

  localparam logic [13:0] BASE_WADDR = BASE_ADDR[14:1];

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SNAP = 3'd1,
    ST_RD0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4,
    ST_RD3  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      step_nxt_s;
  logic        bus_state_s;
  logic [1:0]  we_req_s;
  logic [1:0]  addr_off_s;
  logic        per_en_s;
  logic [1:0]  per_we_s;
  logic [13:0] per_addr_s;
  logic        done_entry_s;
  logic [47:0] shadow_r;
  logic [63:0] new_val_s;
  logic [63:0] tsc_val_r;
  logic        tsc_vld_r;
  logic        busy_r;

  assign new_val_s = {bus.per_dout, shadow_r};

  // Next-state and bus drive; a bus state only advances in a granted cycle.
  always_comb begin
    state_nxt_s  = state_r;
    step_nxt_s   = ST_IDLE;
    bus_state_s  = 1'b0;
    we_req_s     = 2'b00;
    addr_off_s   = 2'd0;
    per_en_s     = 1'b0;
    per_we_s     = 2'b00;
    per_addr_s   = 14'h0000;
    done_entry_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SNAP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SNAP: begin
        bus_state_s = 1'b1;
        we_req_s    = 2'b11;
        addr_off_s  = 2'd0;
        step_nxt_s  = ST_RD0;
      end
      ST_RD0: begin
        bus_state_s = 1'b1;
        addr_off_s  = 2'd0;
        step_nxt_s  = ST_RD1;
      end
      ST_RD1: begin
        bus_state_s = 1'b1;
        addr_off_s  = 2'd1;
        step_nxt_s  = ST_RD2;
      end
      ST_RD2: begin
        bus_state_s = 1'b1;
        addr_off_s  = 2'd2;
        step_nxt_s  = ST_RD3;
      end
      ST_RD3: begin
        bus_state_s = 1'b1;
        addr_off_s  = 2'd3;
        step_nxt_s  = ST_DONE;
      end
      ST_DONE: begin
        if (tsc_ack) begin
          if (start) begin
            state_nxt_s = ST_SNAP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    per_en_s = bus_state_s & bus.per_gnt;
    if (per_en_s) begin
      per_we_s     = we_req_s;
      per_addr_s   = BASE_WADDR + {12'h000, addr_off_s};
      state_nxt_s  = step_nxt_s;
      done_entry_s = (state_r == ST_RD3);
    end else begin
      per_we_s     = 2'b00;
      per_addr_s   = 14'h0000;
    end
  end

  // State register.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Word capture into the shadow; tsc_val only changes as a whole on DONE entry.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      shadow_r  <= 48'h0;
      tsc_val_r <= 64'h0;
      tsc_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (per_en_s) begin
        case (state_r)
          ST_RD0:  shadow_r[15:0]  <= bus.per_dout;
          ST_RD1:  shadow_r[31:16] <= bus.per_dout;
          ST_RD2:  shadow_r[47:32] <= bus.per_dout;
          default: shadow_r        <= shadow_r;
        endcase
      end
      if (done_entry_s) begin
        tsc_val_r <= new_val_s;
        tsc_vld_r <= 1'b1;
      end else if ((state_r == ST_DONE) && tsc_ack) begin
        tsc_vld_r <= 1'b0;
      end else begin
        tsc_vld_r <= tsc_vld_r;
      end
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef TSC_READER_DELTA_EN
  logic [63:0] prev_r;
  logic [63:0] tsc_delta_r;

  // Delta against the previous fetch; unsigned subtraction wraps naturally.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      prev_r      <= 64'h0;
      tsc_delta_r <= 64'h0;
    end else if (done_entry_s) begin
      tsc_delta_r <= new_val_s - prev_r;
      prev_r      <= new_val_s;
    end else begin
      prev_r      <= prev_r;
      tsc_delta_r <= tsc_delta_r;
    end
  end

  assign tsc_delta = tsc_delta_r;
`else
  assign tsc_delta = 64'h0;
`endif

  assign bus.per_req  = bus_state_s;
  assign bus.per_en   = per_en_s;
  assign bus.per_we   = per_we_s;
  assign bus.per_addr = per_addr_s;
  assign bus.per_din  = 16'h0000;
  assign tsc_val      = tsc_val_r;
  assign tsc_vld      = tsc_vld_r;
  assign busy         = busy_r;

  omsp_tsc_reader_chk u_chk (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_req  (bus_state_s),
    .per_en   (per_en_s),
    .per_we   (per_we_s),
    .per_addr (per_addr_s),
    .tsc_vld  (tsc_vld_r),
    .busy     (busy_r)
  );

endmodule

// File: tb/tb_omsp_tsc_reader.sv
// Directed bench for omsp_tsc_reader with a TSC peripheral model and an expected-value queue.
module tb_omsp_tsc_reader;

  logic        mclk;
  logic        puc_rst;
  logic        start;
  logic        tsc_ack;
  logic        busy;
  logic [63:0] tsc_val;
  logic        tsc_vld;
  logic [63:0] tsc_delta;

  omsp_tsc_reader_if bus ();

  omsp_tsc_reader #(.BASE_ADDR(15'h0100)) dut (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .start     (start),
    .busy      (busy),
    .tsc_val   (tsc_val),
    .tsc_vld   (tsc_vld),
    .tsc_ack   (tsc_ack),
    .tsc_delta (tsc_delta),
    .bus       (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [63:0] held_v;
  logic        model_tsc;
  logic [63:0] fix_w;
  logic [63:0] cnt_r;
  logic [63:0] snap_r;
  logic [63:0] src_s;

  // TSC peripheral model: free-running counter, snapshot on write to its base word.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      cnt_r  <= 64'h0;
      snap_r <= 64'h0;
    end else begin
      cnt_r <= cnt_r + 64'd1;
      if (bus.per_en && bus.per_we == 2'b11 && bus.per_addr == 14'h0080)
        snap_r <= cnt_r;
    end
  end

  always_comb begin
    src_s = model_tsc ? snap_r : fix_w;
    bus.per_dout = 16'hDEAD;
    if (bus.per_en && bus.per_we == 2'b00 && bus.per_addr[13:2] == 12'h020) begin
      case (bus.per_addr[1:0])
        2'd0:    bus.per_dout = src_s[15:0];
        2'd1:    bus.per_dout = src_s[31:16];
        2'd2:    bus.per_dout = src_s[47:32];
        default: bus.per_dout = src_s[63:48];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge mclk);
    #1;
    cyc_n++;
  endtask

  function automatic logic [63:0] busw();
    return {31'h0, bus.per_en, bus.per_we, bus.per_addr, bus.per_din};
  endfunction

  function automatic logic [63:0] rd_w(input int k);
    logic [13:0] a;
    a = 14'h0080 + 14'(k);
    return {31'h0, 1'b1, 2'b00, a, 16'h0000};
  endfunction

  // Advance until tsc_vld, counting cycles from n0; compare latency and popped value.
  task automatic wait_vld(input string tag, input int n0, input int exp_lat);
    int n;
    n = n0;
    do begin
      cyc();
      start = 1'b0;
      n++;
      @(negedge mclk);
    end while (!tsc_vld && n < n0 + 40);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    else exp_v = 64'hxxxx_xxxx_xxxx_xxxx;
    chk({tag, "_val"}, tsc_val, exp_v);
    held_v = exp_v;
  endtask

  task automatic do_ack(input string tag);
    cyc();
    tsc_ack = 1'b1;
    start   = 1'b0;
    @(negedge mclk);
    cyc();
    tsc_ack = 1'b0;
    @(negedge mclk);
    chk({tag, "_ack"}, {62'h0, busy, tsc_vld}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    puc_rst     = 1'b1;
    start       = 1'b0;
    tsc_ack     = 1'b0;
    bus.per_gnt = 1'b1;
    model_tsc   = 1'b0;
    fix_w       = 64'h4444_3333_2222_1111;
    #1;
    chk("rst_out", {58'h0, busy, tsc_vld, bus.per_req, bus.per_en, bus.per_we}, 64'h0);
    chk("rst_val", tsc_val, 64'h0);
    chk("rst_delta", tsc_delta, 64'h0);
    cyc();
    cyc();
    puc_rst = 1'b0;

    // Basic fetch with full bus trace
    cyc();
    start = 1'b1;
    exp_q.push_back(64'h4444_3333_2222_1111);
    @(negedge mclk);
    chk("t1_idle_busy", {63'h0, busy}, 64'h0);
    cyc();
    start = 1'b0;
    @(negedge mclk);
    chk("t1_snap", busw(), {31'h0, 1'b1, 2'b11, 14'h0080, 16'h0000});
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge mclk);
      chk($sformatf("t1_rd%0d", k), busw(), rd_w(k));
      chk($sformatf("t1_novld%0d", k), {63'h0, tsc_vld}, 64'h0);
    end
    wait_vld("t1", 5, 6);
    do_ack("t1");

    // Grant stall in RD1
    fix_w = 64'h0123_4567_89AB_CDEF;
    cyc();
    start = 1'b1;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    cyc();
    start = 1'b0;
    cyc();
    for (int s = 0; s < 3; s++) begin
      cyc();
      bus.per_gnt = 1'b0;
      @(negedge mclk);
      chk($sformatf("t2_stall%0d", s), {busw()[63:33], bus.per_req, busw()[31:0]},
          {31'h0, 1'b1, 32'h0});
    end
    cyc();
    bus.per_gnt = 1'b1;
    @(negedge mclk);
    chk("t2_resume", busw(), rd_w(1));
    wait_vld("t2", 6, 9);
    do_ack("t2");

    // Handshake hold, ignored start, back-to-back fetch
    fix_w = 64'hA5A5_0F0F_1234_8765;
    cyc();
    start = 1'b1;
    exp_q.push_back(64'hA5A5_0F0F_1234_8765);
    wait_vld("t3a", 0, 6);
    fix_w = 64'h5A5A_F0F0_CAFE_0042;
    for (int i = 0; i < 10; i++) begin
      cyc();
      start = 1'(i % 2);
      @(negedge mclk);
      chk($sformatf("t3_hold%0d", i), {63'h0, tsc_vld}, 64'h1);
      chk($sformatf("t3_held%0d", i), tsc_val, held_v);
    end
    cyc();
    tsc_ack = 1'b1;
    start   = 1'b1;
    exp_q.push_back(64'h5A5A_F0F0_CAFE_0042);
    cyc();
    tsc_ack = 1'b0;
    start   = 1'b0;
    @(negedge mclk);
    chk("t3_b2b_snap", busw(), {31'h0, 1'b1, 2'b11, 14'h0080, 16'h0000});
    chk("t3_b2b_vld", {63'h0, tsc_vld}, 64'h0);
    wait_vld("t3b", 1, 6);
    do_ack("t3");

    // Reset in RD2, then a fresh fetch
    fix_w = 64'h1111_2222_3333_4444;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    puc_rst = 1'b1;
    #1;
    chk("t4_rst_ctl", {58'h0, busy, tsc_vld, bus.per_req, bus.per_en, bus.per_we}, 64'h0);
    chk("t4_rst_addr", {50'h0, bus.per_addr}, 64'h0);
    chk("t4_rst_val", tsc_val, 64'h0);
    cyc();
    puc_rst = 1'b0;
    fix_w = 64'hBEEF_0001_C0DE_7777;
    cyc();
    start = 1'b1;
    exp_q.push_back(64'hBEEF_0001_C0DE_7777);
    wait_vld("t4", 0, 6);
    do_ack("t4");

    // Integration with the TSC model: reset release is cycle 0
    model_tsc = 1'b1;
    cyc();
    puc_rst = 1'b1;
    cyc();
    puc_rst = 1'b0;
    cyc_n = 0;
    while (cyc_n < 10) cyc();
    start = 1'b1;
    exp_q.push_back(64'd11);
    wait_vld("t5a", 0, 6);
    do_ack("t5a");
    while (cyc_n < 60) cyc();
    start = 1'b1;
    exp_q.push_back(64'd61);
    wait_vld("t5b", 0, 6);
    do_ack("t5b");

    // Delta across a wrap
    model_tsc = 1'b0;
    cyc();
    puc_rst = 1'b1;
    cyc();
    puc_rst = 1'b0;
    fix_w = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    start = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    wait_vld("t6a", 0, 6);
`ifdef TSC_READER_DELTA_EN
    chk("t6a_delta", tsc_delta, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    chk("t6a_delta", tsc_delta, 64'h0);
`endif
    do_ack("t6a");
    fix_w = 64'h0000_0000_0000_0003;
    cyc();
    start = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_0003);
    wait_vld("t6b", 0, 6);
`ifdef TSC_READER_DELTA_EN
    chk("t6b_delta", tsc_delta, 64'h5);
`else
    chk("t6b_delta", tsc_delta, 64'h0);
`endif
    do_ack("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
